// File: rtl/cnn_layer_accel_awe_weight_reader.sv
// Streams a burst of weight words from a synchronous-read table into a ready/valid port.
// Reads are issued only while the output buffer can absorb every outstanding read.
module cnn_layer_accel_awe_weight_reader #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned N_DEPTH = 256,
  parameter int unsigned W_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W_DEPTH-1:0] base_addr,
  input  logic [W_DEPTH:0]   num_words,
  output logic               busy,
  output logic               done,
  output logic [W_DEPTH-1:0] ram_addr,
  output logic               ram_we,
  output logic [WIDTH-1:0]   ram_din,
  input  logic [WIDTH-1:0]   ram_dout,
  output logic [WIDTH-1:0]   wt_data,
  output logic               wt_valid,
  input  logic               wt_ready,
  output logic               wt_last
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [W_DEPTH-1:0] AddrMax = W_DEPTH'(N_DEPTH - 1);
  localparam logic [W_DEPTH:0]   CntOne  = {{W_DEPTH{1'b0}}, 1'b1};
  localparam logic [W_DEPTH:0]   CntZero = '0;

  // Head slot drives wt_data; the two slots behind it absorb reads still in the RAM pipeline.
  localparam int unsigned Slots = 3;

  logic [1:0]         state_q, state_d;
  logic [W_DEPTH-1:0] addr_q, addr_d;
  logic [W_DEPTH:0]   iss_rem_q, iss_rem_d;
  logic [W_DEPTH:0]   out_rem_q, out_rem_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   fifo_q [Slots];
  logic [WIDTH-1:0]   fifo_d [Slots];
  logic [1:0]         wr_ptr_q, wr_ptr_d;
  logic [1:0]         rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;

  logic               push;
  logic               pop;
  logic               issue;
  logic               can_issue;
  logic [2:0]         pending;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    push      = s2_q;
    pop       = (cnt_q != 2'd0) && wt_ready;
    // Stored words plus every read that will still land, less the word leaving now.
    pending   = 3'(cnt_q) + 3'(s1_q) + 3'(s2_q) - 3'(pop);
    can_issue = pending < 3'(Slots);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    iss_rem_d = iss_rem_q;
    out_rem_d = out_rem_q;
    done_d    = 1'b0;
    issue     = 1'b0;

    if (pop) begin
      out_rem_d = out_rem_q - CntOne;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          if (num_words == CntZero) begin
            done_d = 1'b1;
          end else begin
            issue     = 1'b1;
            addr_d    = base_addr;
            iss_rem_d = num_words - CntOne;
            out_rem_d = num_words;
            state_d   = (num_words == CntOne) ? StDrain : StFetch;
          end
        end
      end
      StFetch: begin
        if (can_issue) begin
          issue     = 1'b1;
          addr_d    = (addr_q == AddrMax) ? '0 : addr_q + 1'b1;
          iss_rem_d = iss_rem_q - CntOne;
          if (iss_rem_q == CntOne) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && (out_rem_q == CntOne)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    s1_d     = issue;
    s2_d     = s1_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      fifo_d[wr_ptr_q] = ram_dout;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      iss_rem_q <= '0;
      out_rem_q <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      cnt_q     <= 2'd0;
      for (int i = 0; i < int'(Slots); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      iss_rem_q <= iss_rem_d;
      out_rem_q <= out_rem_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      fifo_q    <= fifo_d;
    end
  end

  always_comb begin
    busy     = (state_q != StIdle);
    done     = done_q;
    ram_addr = addr_q;
    ram_we   = 1'b0;
    ram_din  = '0;
    wt_valid = (cnt_q != 2'd0);
    wt_data  = wt_valid ? fifo_q[rd_ptr_q] : '0;
    wt_last  = wt_valid && (out_rem_q == CntOne);
  end

endmodule
